// File: rtl/led_cnt_multi.sv
// ---------------------------------------------------------------------------
// led_cnt_multi
//
// Multi-pattern LED driver. A prescaler divides clk100 down to a base tick,
// a programmable divider turns base ticks into pattern steps, and on every
// step the LED pattern advances according to the selected mode:
//   0 = up-count, 1 = down-count, 2 = walking-one, 3 = bounce.
// A one-cycle wrap pulse accompanies the step that completes a pattern cycle.
//
// Ports
//   clk100    in   1        system clock (100 MHz), rising edge only
//   rstn      in   1        asynchronous active-low reset
//   div_i     in   DIV_W    step divider: one step every (div_i+1) base ticks
//   mode_i    in   2        pattern mode select
//   wren_i    in   1        load strobe: captures div_i/mode_i, restarts
//   led_o     out  NUM_LED  registered LED pattern
//   led_int_o out  1        registered one-cycle wrap pulse
// ---------------------------------------------------------------------------
module led_cnt_multi #(
  parameter int NUM_LED  = 4,
  parameter int DIV_W    = 5,
  parameter int PRESCALE = 1_000_000
) (
  input  logic               clk100,
  input  logic               rstn,
  input  logic [DIV_W-1:0]   div_i,
  input  logic [1:0]         mode_i,
  input  logic               wren_i,
  output logic [NUM_LED-1:0] led_o,
  output logic               led_int_o
);

  // PRESCALE=1 still needs a one-bit counter; it simply never leaves 0.
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0]   PRE_ONE  = PRE_W'(1);
  localparam logic [DIV_W-1:0]   DIV_ONE  = DIV_W'(1);
  localparam logic [NUM_LED-1:0] LED_ONE  = NUM_LED'(1);

  localparam logic [1:0] MODE_UP     = 2'd0;
  localparam logic [1:0] MODE_DOWN   = 2'd1;
  localparam logic [1:0] MODE_WALK   = 2'd2;
  localparam logic [1:0] MODE_BOUNCE = 2'd3;

  // Pattern loaded when a new setting is written.
  function automatic logic [NUM_LED-1:0] start_pattern(input logic [1:0] mode);
    logic [NUM_LED-1:0] pat;
    case (mode)
      MODE_UP:   pat = '0;
      MODE_DOWN: pat = '1;
      default:   pat = LED_ONE;
    endcase
    return pat;
  endfunction

  // Shadow settings and counters
  logic [DIV_W-1:0]   r_div;
  logic [1:0]         r_mode;
  logic [PRE_W-1:0]   r_pre_cnt;
  logic [DIV_W-1:0]   r_div_cnt;
  logic               r_dir;       // bounce direction, 0 = toward MSB
  logic [NUM_LED-1:0] r_led;
  logic               r_led_int;

  // Step generation
  logic w_tick;
  logic w_div_hit;
  logic w_step;

  assign w_tick    = (r_pre_cnt == PRE_LAST);
  assign w_div_hit = (r_div_cnt == r_div);
  assign w_step    = w_tick & w_div_hit;

  // Candidate next pattern for each mode
  logic [NUM_LED-1:0] w_led_inc;
  logic [NUM_LED-1:0] w_led_dec;
  logic [NUM_LED-1:0] w_led_rol;
  logic [NUM_LED-1:0] w_led_shl;
  logic [NUM_LED-1:0] w_led_shr;

  assign w_led_inc = r_led + LED_ONE;
  assign w_led_dec = r_led - LED_ONE;
  assign w_led_rol = {r_led[NUM_LED-2:0], r_led[NUM_LED-1]};
  assign w_led_shl = r_led << 1;
  assign w_led_shr = r_led >> 1;

  // Selected next pattern, wrap flag and next bounce direction
  logic [NUM_LED-1:0] w_led_nxt;
  logic               w_wrap;
  logic               w_dir_nxt;

  always_comb begin
    w_led_nxt = r_led;
    w_wrap    = 1'b0;
    w_dir_nxt = r_dir;
    case (r_mode)
      MODE_UP: begin
        w_led_nxt = w_led_inc;
        w_wrap    = &r_led;
      end
      MODE_DOWN: begin
        w_led_nxt = w_led_dec;
        w_wrap    = (r_led == '0);
      end
      MODE_WALK: begin
        w_led_nxt = w_led_rol;
        w_wrap    = r_led[NUM_LED-1];
      end
      MODE_BOUNCE: begin
        // Reaching either end reverses direction and counts as a wrap.
        if (!r_dir) begin
          w_led_nxt = w_led_shl;
          if (w_led_shl[NUM_LED-1]) begin
            w_wrap    = 1'b1;
            w_dir_nxt = 1'b1;
          end
        end else begin
          w_led_nxt = w_led_shr;
          if (w_led_shr[0]) begin
            w_wrap    = 1'b1;
            w_dir_nxt = 1'b0;
          end
        end
      end
      default: begin
        w_led_nxt = r_led;
      end
    endcase
  end

  // Settings: captured only on a load strobe
  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      r_div  <= '0;
      r_mode <= MODE_UP;
    end else if (wren_i) begin
      r_div  <= div_i;
      r_mode <= mode_i;
    end
  end

  // Prescaler and divider: a load discards any partial count
  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      r_pre_cnt <= '0;
      r_div_cnt <= '0;
    end else if (wren_i) begin
      r_pre_cnt <= '0;
      r_div_cnt <= '0;
    end else begin
      r_pre_cnt <= w_tick ? '0 : (r_pre_cnt + PRE_ONE);
      if (w_tick) begin
        r_div_cnt <= w_div_hit ? '0 : (r_div_cnt + DIV_ONE);
      end
    end
  end

  // Pattern, direction and wrap pulse; a load takes priority over a step
  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      r_led     <= '0;
      r_dir     <= 1'b0;
      r_led_int <= 1'b0;
    end else if (wren_i) begin
      r_led     <= start_pattern(mode_i);
      r_dir     <= 1'b0;
      r_led_int <= 1'b0;
    end else begin
      if (w_step) begin
        r_led <= w_led_nxt;
        r_dir <= w_dir_nxt;
      end
      r_led_int <= w_step & w_wrap;
    end
  end

  assign led_o     = r_led;
  assign led_int_o = r_led_int;

endmodule
